mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
Arbitrates the single-port data memory (addr / we / w_data / r_data) between two requesters: instruction fetch (I port, read-only) and load/store unit (D port, read/write). Uses a valid/ready request handshake and a valid/ready response handshake per port. Runs one memory transaction at a time through a 3-state FSM. Sits between the CPU core and the memory instance; the memory port signals connect straight to it.

Parameters:
ADDR_W, 32, address width passed to memory
DATA_W, 32, data width of memory words

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
i_req_valid  in  1  fetch request present
i_req_ready  out  1  fetch request accepted this cycle
i_req_addr  in  ADDR_W  fetch address
i_resp_valid  out  1  fetch read data available
i_resp_ready  in  1  fetch consumer takes response
i_resp_data  out  DATA_W  fetch read data
d_req_valid  in  1  load/store request present
d_req_ready  out  1  load/store request accepted this cycle
d_req_addr  in  ADDR_W  load/store address
d_req_we  in  1  1=store, 0=load
d_req_wdata  in  DATA_W  store data
d_resp_valid  out  1  load data / store ack available
d_resp_ready  in  1  LSU takes response
d_resp_data  out  DATA_W  load data (0 for store ack)
mem_addr  out  ADDR_W  memory address
mem_we  out  1  memory write enable
mem_w_data  out  DATA_W  memory write data
mem_r_data  in  DATA_W  memory read data, combinational from mem_addr

Behaviour:
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- IDLE: arbitrate among asserted req_valid.
  - Winner's req_ready=1 (combinational; only in IDLE; never both ports).
  - On accept: latch addr / we / wdata / owner, go to ACCESS.
  - With no valid request, stay in IDLE.
- ACCESS (exactly 1 cycle):
  - mem_addr = latched addr.
  - mem_we = latched we (always 0 for I port).
  - mem_w_data = latched wdata.
  - For loads, capture mem_r_data into the response register at the end of the cycle. For stores, the response register = 0.
  - Go to RESP.
- RESP: owner's resp_valid=1 with resp_data stable. Stay until owner's resp_ready=1, then go to IDLE. No request is accepted in RESP.
- Latency: accept at cycle N -> memory access at N+1 -> resp_valid at N+2. Minimum 3 cycles per transaction.
- Outside ACCESS: mem_we=0, mem_addr = last latched address, mem_w_data = last latched wdata. Memory is never written outside ACCESS.
- Only the owning port sees resp_valid; the other port's resp_valid=0 and its resp_data holds its previous value.
- Reset values:
  - req_ready and resp_valid both 0.
  - mem_we=0.
  - mem_addr, mem_w_data, i_resp_data, d_resp_data all 0.
  - Round-robin pointer set so D wins the first contention.
- Reset mid-operation: the transaction is dropped with no response; the cycle after rst, state=IDLE and mem_we=0. A store already in ACCESS when rst rises has completed its memory write on that edge.
- Requests are sampled only in the accept cycle; later changes on req_addr / we / wdata have no effect.
- Addresses pass through unmodified, full width; memory decodes them.

Optional Feature:
MEM_ARB_RR_EN
- Defined: round-robin. On simultaneous valid, grant the port not granted last; the pointer updates on every accept, including uncontended ones.
- Undefined: fixed priority, D always beats I; no pointer register.
- Single-requester behaviour is identical in both builds.

Test Plan:
- D store addr=0x00012345 wdata=0x00054321 -> d_req_ready in IDLE; mem_we=1 for exactly one cycle at N+1 with mem_addr=0x00012345; d_resp_valid at N+2 with d_resp_data=0.
- I read addr=0x00012345 after the store -> i_resp_valid at N+2, i_resp_data=0x00054321; d_resp_valid stays 0.
- D load addr=0x00011345 (never written, memory preloaded 0) -> d_resp_data=0x00000000, not 0x00054321.
- Both valid every cycle after reset, resp_ready=1 -> with MEM_ARB_RR_EN: grants D, I, D, I; without it: D, D, D and I never granted.
- Hold d_resp_ready=0 for 5 cycles during RESP -> d_resp_valid=1 and d_resp_data stable throughout; i_req_ready=0 despite i_req_valid=1; I accepted in the cycle after the D response handshake (FSM back in IDLE).
- Assert rst during ACCESS of a load -> next cycle: state IDLE, all resp_valid=0, mem_we=0; no stale response afterwards; a new request is accepted normally.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter for a single-port data memory, one transaction at a time.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise D has fixed priority over I.
module mem_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req_valid,
    output logic              i_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_resp_valid,
    input  logic              i_resp_ready,
    output logic [DATA_W-1:0] i_resp_data,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic              d_req_we,
    input  logic [DATA_W-1:0] d_req_wdata,
    output logic              d_resp_valid,
    input  logic              d_resp_ready,
    output logic [DATA_W-1:0] d_resp_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_w_data,
    input  logic [DATA_W-1:0] mem_r_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic              r_we;
    logic [DATA_W-1:0] r_wdata;
    logic              r_owner_d;
    logic [DATA_W-1:0] r_i_resp_data;
    logic [DATA_W-1:0] r_d_resp_data;
    logic              w_grant_i;
    logic              w_grant_d;
    logic              w_accept;

`ifdef MEM_ARB_RR_EN
    // Set when D won the most recent accept; reset so D wins the first contention.
    logic              r_last_d;
`endif

    assign w_accept     = w_grant_i | w_grant_d;
    assign i_req_ready  = w_grant_i;
    assign d_req_ready  = w_grant_d;
    assign mem_addr     = r_addr;
    assign mem_w_data   = r_wdata;
    assign i_resp_data  = r_i_resp_data;
    assign d_resp_data  = r_d_resp_data;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, grants and memory/response strobes
    always_comb begin
        w_next       = r_state;
        w_grant_i    = 1'b0;
        w_grant_d    = 1'b0;
        mem_we       = 1'b0;
        i_resp_valid = 1'b0;
        d_resp_valid = 1'b0;
        case (r_state)
            IDLE: begin
                if (d_req_valid && i_req_valid) begin
`ifdef MEM_ARB_RR_EN
                    w_grant_d = ~r_last_d;
                    w_grant_i = r_last_d;
`else
                    w_grant_d = 1'b1;
`endif
                end else begin
                    w_grant_d = d_req_valid;
                    w_grant_i = i_req_valid;
                end
                if (w_grant_i || w_grant_d) begin
                    w_next = ACCESS;
                end
            end
            ACCESS: begin
                mem_we = r_we;
                w_next = RESP;
            end
            RESP: begin
                if (r_owner_d) begin
                    d_resp_valid = 1'b1;
                    if (d_resp_ready) begin
                        w_next = IDLE;
                    end
                end else begin
                    i_resp_valid = 1'b1;
                    if (i_resp_ready) begin
                        w_next = IDLE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Request latch and response capture; fetch accepts leave the write data untouched
    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr        <= '0;
            r_we          <= 1'b0;
            r_wdata       <= '0;
            r_owner_d     <= 1'b0;
            r_i_resp_data <= '0;
            r_d_resp_data <= '0;
`ifdef MEM_ARB_RR_EN
            r_last_d      <= 1'b0;
`endif
        end else begin
            if (w_accept) begin
                r_owner_d <= w_grant_d;
                r_addr    <= w_grant_d ? d_req_addr : i_req_addr;
                r_we      <= w_grant_d & d_req_we;
                if (w_grant_d) begin
                    r_wdata <= d_req_wdata;
                end
`ifdef MEM_ARB_RR_EN
                r_last_d  <= w_grant_d;
`endif
            end
            if (r_state == ACCESS) begin
                if (r_owner_d) begin
                    r_d_resp_data <= r_we ? '0 : mem_r_data;
                end else begin
                    r_i_resp_data <= mem_r_data;
                end
            end
        end
    end

endmodule
